ddr_sa_2ph_ofs_cal_ctrl: RTL and testbench
==========================================

Name: ddr_sa_2ph_ofs_cal_ctrl

Overview:
- Parametrised offset-calibration controller for NUM_CH two-phase sense amplifiers, with a 0-degree and a 180-degree slice per channel.
- Runs a hardware code sweep while the amps are in cal mode (input shorted to vref), detects the output flip per lane and locks each lane's cal code/dir.
- Outputs feed the SA wrapper cfg fields (cal code, cal dir, cal enable) directly.
- Generalises the fixed-config, software-only cal of the single-SA wrapper to N channels with autonomous calibration.

Parameters:
- NUM_CH, 9, number of SA channels; lanes = 2*NUM_CH.
- CAL_W, 5, cal code magnitude width.
- SETTLE_W, 4, settle-cycle count width.
- SMP_W, 4, sample-count width.

Ports:
- i_clk  in  1  controller clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  one-cycle start pulse; ignored unless in IDLE.
- i_cal_en  in  1  run enable; deassertion aborts.
- i_settle_cyc  in  SETTLE_W  settle cycles after each code change.
- i_num_smp  in  SMP_W  samples per step; 0 is treated as 1.
- i_data_0  in  NUM_CH  0-phase SA outputs, already synchronised to i_clk.
- i_data_180  in  NUM_CH  180-phase SA outputs, already synchronised to i_clk.
- o_sacal_en  out  1  drives SA cal enable.
- o_cal_code_0  out  NUM_CH*CAL_W  per-channel code, 0 phase (channel c at [c*CAL_W +: CAL_W]).
- o_cal_dir_0  out  NUM_CH  per-channel direction, 0 phase.
- o_cal_code_180  out  NUM_CH*CAL_W  same layout, 180 phase.
- o_cal_dir_180  out  NUM_CH  180 phase.
- o_busy  out  1  sweep in progress.
- o_done  out  1  level; set at completion, cleared by start or abort.
- o_err  out  2*NUM_CH  lane never flipped; bits [NUM_CH-1:0] = 0 phase, upper bits = 180 phase.

Behaviour:
- Reset: all codes/dirs 0, o_sacal_en=0, o_busy=0, o_done=0, o_err=0, FSM=IDLE.
- Step index s, CAL_W+1 bits, 0..2^(CAL_W+1)-1. Mapping is monotonic in offset:
  - s<2^CAL_W: dir=0, code=2^CAL_W-1-s.
  - else: dir=1, code=s-2^CAL_W.
- FSM:
  - IDLE: i_start&i_cal_en -> APPLY. Clear o_done, o_err and lock flags; o_busy=1, o_sacal_en=1.
  - APPLY: 1 cycle. Unlocked lanes take mapping(s). Load settle counter = i_settle_cyc. -> SETTLE, or -> SAMPLE if i_settle_cyc==0.
  - SETTLE: decrement; at 1 -> SAMPLE.
  - SAMPLE: max(i_num_smp,1) cycles, one sample per cycle. Per-lane ones counter, SMP_W+1 bits. -> EVAL.
  - EVAL: per lane, vote = (2*ones > nsmp); ties give 0.
    - If s==0: store ref vote.
    - Else, for an unlocked lane with vote != ref: lock it and keep its current code.
    - Clear ones counters.
    - If all lanes locked or s==max -> FIN; else s++ -> APPLY.
  - FIN: o_err = ~locked. Errored lanes forced to dir=0, code=0. o_busy=0, o_sacal_en=0, o_done=1 -> IDLE.
- Step latency = 1 + i_settle_cyc + max(i_num_smp,1) + 1 cycles. Full sweep = 2^(CAL_W+1) steps.
- Abort: i_cal_en=0 in any non-IDLE state -> IDLE next cycle.
  - All codes/dirs -> 0; o_busy, o_sacal_en -> 0.
  - o_done stays 0; o_err unchanged from clear (0).
- i_start while busy: ignored. i_start with i_cal_en=0: ignored.
- Input settings are sampled at each use; changing them mid-sweep affects only later steps.
- Locked lane codes hold until next start or reset. Async reset mid-sweep returns everything to reset values immediately.

Decomposition:
- Package ddr_sa_cal_pkg:
  - FSM state enum (IDLE, APPLY, SETTLE, SAMPLE, EVAL, FIN).
  - step->(dir,code) mapping function.
  - Lane index constants.
- Sub-module ddr_sa_cal_lane, instantiated 2*NUM_CH times:
  - Holds ones counter, ref vote, lock flag, code/dir regs.
  - Controlled by shared apply/sample/eval/clr strobes from the top FSM.

Test Plan:
- NUM_CH=1, CAL_W=5, settle=0, nsmp=1. Data_0 low until code reaches dir=1 code=3 (s=35), then high -> lane0 locks at dir=1/code=3, o_err=0. o_done rises 36*3+1 cycles after start, when data_180 also flips at/before s=35.
- Data_180 constant 0 -> o_err[1]=1, o_cal_code_180=0/dir=0 at done, full 64-step sweep.
- nsmp=3, data pattern 1,0,1 at one step -> vote=1. nsmp=2 pattern 1,0 -> tie -> vote=0. nsmp=0 -> one sample per step.
- Drop i_cal_en at step 10 -> IDLE next cycle, all codes 0, o_done=0, o_busy=0. Re-start completes normally.
- NUM_CH=9, lanes flipping at distinct steps -> each lane holds its own code. Sweep ends early once the last lane locks; extra i_start pulses during busy have no effect.
- Assert i_rst_n low mid-SETTLE -> outputs at reset values asynchronously, without a clock edge.

Source files
------------

// File: rtl/ddr_sa_cal_pkg.sv
// rtl/ddr_sa_cal_pkg.sv - shared types, lane indexing and step-to-code mapping for SA offset cal
package ddr_sa_cal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_FIN
  } cal_state_t;

  localparam int MAX_CAL_W = 8;
  localparam int PH_0      = 0;
  localparam int PH_180    = 1;

  typedef struct packed {
    logic                 dir;
    logic [MAX_CAL_W-1:0] code;
  } cal_set_t;

  function automatic int lane_idx(input int ph, input int ch, input int num_ch);
    return ph * num_ch + ch;
  endfunction

  // Walks from the most negative offset (dir=0, max code) up to the most positive.
  function automatic cal_set_t step_map(input logic [MAX_CAL_W:0] s, input int cal_w);
    logic [MAX_CAL_W:0] half;
    cal_set_t           r;
    half = (MAX_CAL_W+1)'(1) << cal_w;
    if (s < half) begin
      r.dir  = 1'b0;
      r.code = MAX_CAL_W'(half - s - 1'b1);
    end else begin
      r.dir  = 1'b1;
      r.code = MAX_CAL_W'(s - half);
    end
    return r;
  endfunction

endpackage

// File: rtl/ddr_sa_2ph_ofs_cal_ctrl_if.sv
// rtl/ddr_sa_2ph_ofs_cal_ctrl_if.sv - strobe bus from the cal sequencer to the per-lane trackers
interface ddr_sa_2ph_ofs_cal_ctrl_if #(
  parameter int CAL_W = 5,
  parameter int SMP_W = 4
) ();
  logic             start_clr;
  logic             apply;
  logic             sample;
  logic             eval;
  logic             first;
  logic             abort;
  logic             fin;
  logic             map_dir;
  logic [CAL_W-1:0] map_code;
  logic [SMP_W:0]   nsmp;

  modport master (output start_clr, apply, sample, eval, first, abort, fin, map_dir, map_code, nsmp);
  modport slave  (input  start_clr, apply, sample, eval, first, abort, fin, map_dir, map_code, nsmp);
endinterface

// File: rtl/ddr_sa_cal_lane.sv
// rtl/ddr_sa_cal_lane.sv - one SA slice: sample vote, reference, lock flag and held cal code/dir
module ddr_sa_cal_lane
  import ddr_sa_cal_pkg::*;
#(
  parameter int CAL_W = 5,
  parameter int SMP_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ddr_sa_2ph_ofs_cal_ctrl_if.slave ctl,
  input  logic                     data,
  output logic [CAL_W-1:0]         code,
  output logic                     dir,
  output logic                     locked,
  output logic                     flip
);

  logic [SMP_W:0] ones;
  logic           ref_vote;
  logic           vote;
  logic           lock_now;

  // Strict majority: a tie counts as a 0 vote.
  assign vote     = ({ones, 1'b0} > {1'b0, ctl.nsmp});
  assign flip     = !locked && (vote != ref_vote);
  assign lock_now = ctl.eval && !ctl.first && flip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones     <= '0;
      ref_vote <= 1'b0;
      locked   <= 1'b0;
      code     <= '0;
      dir      <= 1'b0;
    end else if (ctl.abort) begin
      ones   <= '0;
      locked <= 1'b0;
      code   <= '0;
      dir    <= 1'b0;
    end else begin
      if (ctl.start_clr) begin
        ones     <= '0;
        ref_vote <= 1'b0;
        locked   <= 1'b0;
      end
      if (ctl.apply && !locked) begin
        code <= ctl.map_code;
        dir  <= ctl.map_dir;
      end
      if (ctl.sample) ones <= ones + {{SMP_W{1'b0}}, data};
      if (ctl.eval) begin
        ones <= '0;
        if (ctl.first) ref_vote <= vote;
        if (lock_now) locked <= 1'b1;
      end
      if (ctl.fin && !locked) begin
        code <= '0;
        dir  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ddr_sa_2ph_ofs_cal_ctrl.sv
// rtl/ddr_sa_2ph_ofs_cal_ctrl.sv - autonomous offset-cal sweep for NUM_CH two-phase sense amps
module ddr_sa_2ph_ofs_cal_ctrl
  import ddr_sa_cal_pkg::*;
#(
  parameter int NUM_CH   = 9,
  parameter int CAL_W    = 5,
  parameter int SETTLE_W = 4,
  parameter int SMP_W    = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_cal_en,
  input  logic [SETTLE_W-1:0]     i_settle_cyc,
  input  logic [SMP_W-1:0]        i_num_smp,
  input  logic [NUM_CH-1:0]       i_data_0,
  input  logic [NUM_CH-1:0]       i_data_180,
  output logic                    o_sacal_en,
  output logic [NUM_CH*CAL_W-1:0] o_cal_code_0,
  output logic [NUM_CH-1:0]       o_cal_dir_0,
  output logic [NUM_CH*CAL_W-1:0] o_cal_code_180,
  output logic [NUM_CH-1:0]       o_cal_dir_180,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [2*NUM_CH-1:0]     o_err
);

  localparam int LANES = 2 * NUM_CH;

  cal_state_t          state, state_nxt;
  logic [CAL_W:0]      step;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [SMP_W-1:0]    smp_cnt;
  logic [SMP_W-1:0]    nsmp_eff;
  logic [SMP_W:0]      nsmp_q;
  logic [LANES-1:0]    locked, flip, data_all;
  logic [CAL_W-1:0]    code_a [LANES];
  logic [LANES-1:0]    dir_a;
  logic                start_go, abort, load_settle, load_smp, eval_adv, fin;
  logic                apply, sample, eval;
  cal_set_t            map;

  ddr_sa_2ph_ofs_cal_ctrl_if #(.CAL_W(CAL_W), .SMP_W(SMP_W)) ctl ();

  assign nsmp_eff = (i_num_smp == '0) ? SMP_W'(1) : i_num_smp;
  assign map      = step_map((MAX_CAL_W+1)'(step), CAL_W);
  assign data_all = {i_data_180, i_data_0};

  assign ctl.start_clr = start_go;
  assign ctl.apply     = apply;
  assign ctl.sample    = sample;
  assign ctl.eval      = eval;
  assign ctl.first     = (step == '0);
  assign ctl.abort     = abort;
  assign ctl.fin       = fin;
  assign ctl.map_dir   = map.dir;
  assign ctl.map_code  = map.code[CAL_W-1:0];
  assign ctl.nsmp      = nsmp_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_go    = 1'b0;
    abort       = 1'b0;
    load_settle = 1'b0;
    load_smp    = 1'b0;
    eval_adv    = 1'b0;
    fin         = 1'b0;
    apply       = 1'b0;
    sample      = 1'b0;
    eval        = 1'b0;
    if (state != ST_IDLE && !i_cal_en) begin
      abort     = 1'b1;
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (i_start && i_cal_en) begin
          start_go  = 1'b1;
          state_nxt = ST_APPLY;
        end
        ST_APPLY: begin
          apply       = 1'b1;
          load_settle = 1'b1;
          if (i_settle_cyc == '0) begin
            load_smp  = 1'b1;
            state_nxt = ST_SAMPLE;
          end else begin
            state_nxt = ST_SETTLE;
          end
        end
        ST_SETTLE: if (settle_cnt <= SETTLE_W'(1)) begin
          load_smp  = 1'b1;
          state_nxt = ST_SAMPLE;
        end
        ST_SAMPLE: begin
          sample = 1'b1;
          if (smp_cnt <= SMP_W'(1)) state_nxt = ST_EVAL;
        end
        ST_EVAL: begin
          eval = 1'b1;
          // Locks taken this cycle count toward the early exit.
          if (((&(locked | flip)) && (step != '0)) || (&step)) begin
            state_nxt = ST_FIN;
          end else begin
            eval_adv  = 1'b1;
            state_nxt = ST_APPLY;
          end
        end
        ST_FIN: begin
          fin       = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      step       <= '0;
      settle_cnt <= '0;
      smp_cnt    <= '0;
      nsmp_q     <= '0;
      o_busy     <= 1'b0;
      o_sacal_en <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= '0;
    end else begin
      if (start_go)      step <= '0;
      else if (eval_adv) step <= step + 1'b1;
      if (load_settle)             settle_cnt <= i_settle_cyc;
      else if (state == ST_SETTLE) settle_cnt <= settle_cnt - 1'b1;
      // Sample count is captured per step so later changes only affect later steps.
      if (load_smp) begin
        smp_cnt <= nsmp_eff;
        nsmp_q  <= {1'b0, nsmp_eff};
      end else if (state == ST_SAMPLE) begin
        smp_cnt <= smp_cnt - 1'b1;
      end
      if (start_go) begin
        o_busy     <= 1'b1;
        o_sacal_en <= 1'b1;
        o_done     <= 1'b0;
        o_err      <= '0;
      end else if (abort) begin
        o_busy     <= 1'b0;
        o_sacal_en <= 1'b0;
        o_done     <= 1'b0;
      end else if (fin) begin
        o_busy     <= 1'b0;
        o_sacal_en <= 1'b0;
        o_done     <= 1'b1;
        o_err      <= ~locked;
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    ddr_sa_cal_lane #(.CAL_W(CAL_W), .SMP_W(SMP_W)) u_lane (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .ctl    (ctl),
      .data   (data_all[l]),
      .code   (code_a[l]),
      .dir    (dir_a[l]),
      .locked (locked[l]),
      .flip   (flip[l])
    );
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int L0 = lane_idx(PH_0, c, NUM_CH);
    localparam int L1 = lane_idx(PH_180, c, NUM_CH);
    assign o_cal_code_0[c*CAL_W +: CAL_W]   = code_a[L0];
    assign o_cal_dir_0[c]                   = dir_a[L0];
    assign o_cal_code_180[c*CAL_W +: CAL_W] = code_a[L1];
    assign o_cal_dir_180[c]                 = dir_a[L1];
  end

endmodule

// File: tb/tb_ddr_sa_2ph_ofs_cal_ctrl.sv
// tb/tb_ddr_sa_2ph_ofs_cal_ctrl.sv - randomized sweep bench with threshold-based SA plant and reference model
module tb_ddr_sa_2ph_ofs_cal_ctrl;

  localparam int NCH   = 9;
  localparam int CW    = 5;
  localparam int LN    = 2 * NCH;
  localparam int HALF  = 1 << CW;
  localparam int NSTEP = 2 * HALF;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            cal_en;
  logic [3:0]      settle_cyc;
  logic [3:0]      num_smp;
  logic [NCH-1:0]  d0, d180;
  logic            sacal_en;
  logic [NCH*CW-1:0] code0, code180;
  logic [NCH-1:0]  dir0, dir180;
  logic            busy, done;
  logic [LN-1:0]   err;

  int          errs   = 0;
  int          checks = 0;
  int          thr [LN];
  logic [15:0] pat [LN];
  int          nsmp_v;
  int          st_a [LN];
  int          hit  [LN];
  logic [LN-1:0] dall;

  ddr_sa_2ph_ofs_cal_ctrl #(.NUM_CH(NCH), .CAL_W(CW), .SETTLE_W(4), .SMP_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_cal_en(cal_en),
    .i_settle_cyc(settle_cyc), .i_num_smp(num_smp),
    .i_data_0(d0), .i_data_180(d180),
    .o_sacal_en(sacal_en), .o_cal_code_0(code0), .o_cal_dir_0(dir0),
    .o_cal_code_180(code180), .o_cal_dir_180(dir180),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SA plant: output flips high once the applied offset step reaches the lane threshold.
  always_comb begin
    for (int l = 0; l < LN; l++) begin
      int c;
      logic dr;
      if (l < NCH) begin
        c  = int'(code0[l*CW +: CW]);
        dr = dir0[l];
      end else begin
        c  = int'(code180[(l-NCH)*CW +: CW]);
        dr = dir180[l-NCH];
      end
      st_a[l] = dr ? HALF + c : HALF - 1 - c;
      if (st_a[l] > thr[l])       dall[l] = 1'b1;
      else if (st_a[l] == thr[l]) dall[l] = pat[l][hit[l]];
      else                        dall[l] = 1'b0;
    end
    d0   = dall[NCH-1:0];
    d180 = dall[LN-1:NCH];
  end

  always @(posedge clk) begin
    for (int l = 0; l < LN; l++)
      hit[l] <= (st_a[l] == thr[l]) ? ((hit[l] < 15) ? hit[l] + 1 : hit[l]) : 0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int vote_m(input int l, input int s);
    int n, ones;
    n = (nsmp_v == 0) ? 1 : nsmp_v;
    if (s > thr[l]) return 1;
    if (s < thr[l]) return 0;
    ones = 0;
    for (int k = 0; k < n; k++) ones += int'(pat[l][k]);
    return (2 * ones > n) ? 1 : 0;
  endfunction

  task automatic run_sweep(input int settle, input int nsmp, input bit extra, input string tag);
    int lock [LN];
    int last, n, cnt, exp_cyc, s;
    bit all;
    logic [NCH*CW-1:0] ec0, ec180;
    logic [NCH-1:0]    ed0, ed180;
    logic [LN-1:0]     eerr;
    nsmp_v = nsmp;
    n      = (nsmp == 0) ? 1 : nsmp;
    all    = 1'b1;
    last   = 0;
    ec0 = '0; ec180 = '0; ed0 = '0; ed180 = '0; eerr = '0;
    for (int l = 0; l < LN; l++) begin
      int rv;
      rv      = vote_m(l, 0);
      lock[l] = -1;
      for (int t = 1; t < NSTEP; t++)
        if (lock[l] < 0 && vote_m(l, t) != rv) lock[l] = t;
      if (lock[l] < 0) begin
        all     = 1'b0;
        eerr[l] = 1'b1;
      end else begin
        if (lock[l] > last) last = lock[l];
        s = lock[l];
        if (l < NCH) begin
          ec0[l*CW +: CW] = CW'((s < HALF) ? HALF - 1 - s : s - HALF);
          ed0[l]          = (s >= HALF);
        end else begin
          ec180[(l-NCH)*CW +: CW] = CW'((s < HALF) ? HALF - 1 - s : s - HALF);
          ed180[l-NCH]            = (s >= HALF);
        end
      end
    end
    if (!all) last = NSTEP - 1;
    exp_cyc = (last + 1) * (2 + settle + n) + 1;

    settle_cyc = 4'(settle);
    num_smp    = 4'(nsmp);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, ".busy_run"}, 64'(busy), 64'd1);
    chk({tag, ".sacal_run"}, 64'(sacal_en), 64'd1);
    cnt = 0;
    while (!done && cnt < 4000) begin
      @(negedge clk);
      cnt++;
      start = extra && (cnt == 5 || cnt == 9);
    end
    start = 1'b0;
    chk({tag, ".cycles"}, 64'(cnt), 64'(exp_cyc));
    chk({tag, ".busy_end"}, 64'(busy), 64'd0);
    chk({tag, ".sacal_end"}, 64'(sacal_en), 64'd0);
    chk({tag, ".err"}, 64'(err), 64'(eerr));
    chk({tag, ".code0"}, 64'(code0), 64'(ec0));
    chk({tag, ".dir0"}, 64'(dir0), 64'(ed0));
    chk({tag, ".code180"}, 64'(code180), 64'(ec180));
    chk({tag, ".dir180"}, 64'(dir180), 64'(ed180));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cal_en = 1'b1;
    settle_cyc = '0; num_smp = 4'd1; nsmp_v = 1;
    for (int l = 0; l < LN; l++) begin
      thr[l] = 64;
      pat[l] = 16'hFFFF;
    end
    repeat (2) @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.sacal", 64'(sacal_en), 64'd0);
    chk("rst.err", 64'(err), 64'd0);
    chk("rst.code0", 64'(code0), 64'd0);
    chk("rst.code180", 64'(code180), 64'd0);
    chk("rst.dirs", 64'({dir180, dir0}), 64'd0);
    rst_n = 1'b1;

    cal_en = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("noen.busy", 64'(busy), 64'd0);
    chk("noen.sacal", 64'(sacal_en), 64'd0);
    cal_en = 1'b1;

    // Directed: lane0 and lane9 flip at step 35 (dir=1 code=3), others earlier.
    thr[0] = 35; thr[NCH] = 35;
    for (int l = 1; l < NCH; l++) thr[l] = 1 + 2 * l;
    for (int l = NCH + 1; l < LN; l++) thr[l] = 10 + l;
    run_sweep(0, 1, 1'b0, "dir35");
    chk("dir35.c0", 64'(code0[CW-1:0]), 64'd3);
    chk("dir35.d0", 64'(dir0[0]), 64'd1);
    chk("dir35.done", 64'(done), 64'd1);

    thr[NCH] = 64;
    run_sweep(0, 1, 1'b0, "never180");

    for (int l = 0; l < LN; l++) thr[l] = 5;
    thr[2] = 20; pat[2] = 16'h0005;
    run_sweep(0, 3, 1'b0, "maj3");
    pat[2] = 16'h0001;
    run_sweep(0, 2, 1'b0, "tie2");
    pat[2] = 16'hFFFF;
    for (int l = 0; l < LN; l++) thr[l] = $urandom_range(1, 50);
    run_sweep(0, 0, 1'b0, "nsmp0");

    // Abort in the sample phase of step 10.
    for (int l = 0; l < LN; l++) thr[l] = 64;
    settle_cyc = '0; num_smp = 4'd1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (31) @(negedge clk);
    chk("abort.busy_pre", 64'(busy), 64'd1);
    cal_en = 1'b0;
    @(negedge clk);
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.done", 64'(done), 64'd0);
    chk("abort.sacal", 64'(sacal_en), 64'd0);
    chk("abort.codes", 64'(code0 | code180), 64'd0);
    chk("abort.dirs", 64'({dir180, dir0}), 64'd0);
    chk("abort.err", 64'(err), 64'd0);
    cal_en = 1'b1;
    for (int l = 0; l < LN; l++) thr[l] = 3 + 2 * l;
    run_sweep(0, 1, 1'b0, "restart");

    for (int r = 0; r < 6; r++) begin
      for (int l = 0; l < LN; l++) begin
        thr[l] = $urandom_range(1, 63);
        if ($urandom_range(0, 9) == 0) thr[l] = 64;
        if ($urandom_range(0, 15) == 0) thr[l] = 0;
      end
      run_sweep($urandom_range(0, 3), $urandom_range(0, 4), 1'b1, $sformatf("rnd%0d", r));
    end

    // Asynchronous reset while settling.
    settle_cyc = 4'd8; num_smp = 4'd1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst.busy_pre", 64'(busy), 64'd1);
    chk("arst.code_pre", 64'(code0[CW-1:0]), 64'd31);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy", 64'(busy), 64'd0);
    chk("arst.sacal", 64'(sacal_en), 64'd0);
    chk("arst.codes", 64'(code0 | code180), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int l = 0; l < LN; l++) thr[l] = $urandom_range(1, 40);
    run_sweep(2, 2, 1'b0, "postrst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
